// File: rtl/mem_responder.sv
// Unified instruction/data memory that answers held mem_read/mem_write requests
// after a fixed access latency, returning a one-cycle mem_ready pulse.
module mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        mem_ready,
   output logic        busy,
   output logic        req_conflict
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic [31:0]       wdata_q;
   logic [31:0]       dout_q;
   logic              isWrite_q;
   logic              ready_q;
   logic              busy_q;
   logic              conflict_q;
   logic [31:0]       mem_q [DEPTH];

   logic              acceptReq;
   logic              doAccess;
   logic              unusedAddrBits;

   assign acceptReq = (state_q == IDLE) && (mem_read || mem_write);
   assign doAccess  = (state_q == BUSY) && (cnt_q == '0);

   // Byte-offset bits and bits above the index wrap silently.
   assign unusedAddrBits = ^{addr[31:IDX_W+2], addr[1:0]};

   always_ff @(posedge clk) begin
      if (acceptReq) begin
         idx_q     <= addr[IDX_W+1:2];
         wdata_q   <= din;
         isWrite_q <= mem_write;
      end
   end

   // Array has no reset; reset on the access edge must still block the commit.
   always_ff @(posedge clk) begin
      if (!reset && doAccess && isWrite_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dout_q     <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (acceptReq) begin
                  cnt_q      <= CNT_W'(LATENCY - 1);
                  conflict_q <= conflict_q | (mem_read & mem_write);
                  busy_q     <= 1'b1;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  if (!isWrite_q) begin
                     dout_q <= mem_q[idx_q];
                  end
                  ready_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dout         = dout_q;
   assign mem_ready    = ready_q;
   assign busy         = busy_q;
   assign req_conflict = conflict_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver queues expected responses,
// a monitor checks them whenever mem_ready pulses.
module tb_mem_responder;

   typedef struct {
      string       name;
      int          cycle;
      logic [31:0] dout;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memRead = 1'b0;
   logic        memWrite = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        memReady;
   logic        busy;
   logic        reqConflict;

   logic        rd1 = 1'b0;
   logic        wr1 = 1'b0;
   logic [31:0] addr1 = '0;
   logic [31:0] din1 = '0;
   logic [31:0] dout1;
   logic        memReady1;
   logic        busy1;
   logic        reqConflict1;

   int          cyc = 0;
   int          testsRun = 0;
   int          testsFailed = 0;
   bit          started = 1'b0;
   logic        expConflict = 1'b0;
   resp_t       sb[$];

   mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .mem_read(memRead), .mem_write(memWrite),
      .addr(addr), .din(din), .dout(dout), .mem_ready(memReady),
      .busy(busy), .req_conflict(reqConflict)
   );

   mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1),
      .addr(addr1), .din(din1), .dout(dout1), .mem_ready(memReady1),
      .busy(busy1), .req_conflict(reqConflict1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expected response for every mem_ready pulse.
   always @(negedge clk) begin
      if (started && !reset) begin
         if (memReady) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected mem_ready", 32'd1, 32'd0);
            end else begin
               resp_t e;
               e = sb.pop_front();
               checkOutput({e.name, " ready cycle"}, 32'(cyc), 32'(e.cycle));
               checkOutput({e.name, " dout"}, dout, e.dout);
            end
         end
         checkOutput("req_conflict", {31'd0, reqConflict}, {31'd0, expConflict});
      end
   end

   task automatic waitReady(input string nm);
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (memReady) got = 1'b1;
      end
      if (!got) checkOutput({nm, " ready timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
      memWrite = 1'b0;
      memRead  = 1'b0;
   endtask

   // Issues a held request at the start of a cycle and releases it after mem_ready.
   task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] expDout, input string nm);
      memWrite = wr;
      memRead  = rd;
      addr     = a;
      din      = d;
      sb.push_back('{nm, cyc + 3, expDout});
      @(posedge clk);
      #1;
      if (wr && rd) expConflict = 1'b1;
      waitReady(nm);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      started = 1'b1;
      @(negedge clk);
      checkOutput("reset dout", dout, 32'h0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset mem_ready", {31'd0, memReady}, 32'd0);
      checkOutput("reset req_conflict", {31'd0, reqConflict}, 32'd0);
      @(posedge clk);
      #1;

      applyStimulus(1, 0, 32'h30, 32'h0, 32'h0, "init 0x30");
      applyStimulus(1, 0, 32'h10, 32'hDEADBEEF, 32'h0, "write 0x10");
      applyStimulus(0, 1, 32'h10, 32'h0, 32'hDEADBEEF, "read 0x10");

      // Write whose inputs change after acceptance must commit the latched data.
      memWrite = 1'b1;
      addr = 32'h20;
      din = 32'h11111111;
      sb.push_back('{"midflight write", cyc + 3, 32'hDEADBEEF});
      @(posedge clk);
      #1;
      memWrite = 1'b0;
      din = 32'h22222222;
      waitReady("midflight write");
      applyStimulus(0, 1, 32'h20, 32'h0, 32'h11111111, "read 0x20");

      applyStimulus(1, 0, 32'h1003, 32'hA5A5A5A5, 32'h11111111, "write 0x1003");
      applyStimulus(0, 1, 32'h0, 32'h0, 32'hA5A5A5A5, "read wrap 0x0");

      applyStimulus(1, 1, 32'h8, 32'h5, 32'hA5A5A5A5, "conflict write");
      applyStimulus(0, 1, 32'h8, 32'h0, 32'h5, "read 0x8");

      // Reset lands on the access edge of a write: the write must be dropped.
      t = cyc;
      memWrite = 1'b1;
      addr = 32'h30;
      din = 32'hCAFE;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      memWrite = 1'b0;
      expConflict = 1'b0;
      @(negedge clk);
      checkOutput("reset mid cycle", 32'(cyc - t), 32'd3);
      checkOutput("reset mid busy", {31'd0, busy}, 32'd0);
      checkOutput("reset mid mem_ready", {31'd0, memReady}, 32'd0);
      checkOutput("reset mid dout", dout, 32'h0);
      @(posedge clk);
      #1;
      applyStimulus(0, 1, 32'h30, 32'h0, 32'h0, "read 0x30 after reset");

      // LATENCY=1 instance: two reads held continuously.
      begin
         logic expBusy[7]  = '{0, 1, 1, 0, 1, 1, 0};
         logic expReady[7] = '{0, 0, 1, 0, 0, 1, 0};
         rd1 = 1'b1;
         addr1 = 32'h40;
         for (int k = 0; k < 7; k++) begin
            if (k == 6) rd1 = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("lat1 busy c%0d", k), {31'd0, busy1}, {31'd0, expBusy[k]});
            checkOutput($sformatf("lat1 ready c%0d", k), {31'd0, memReady1}, {31'd0, expReady[k]});
            @(posedge clk);
            #1;
         end
      end

      repeat (2) @(posedge clk);
      checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Latency-configurable unified instruction/data memory that answers the `mem_read` / `mem_write` requests issued by the multicycle CPU control path. It latches each request and its address and data, then counts out a fixed access latency. It performs the array read or write and returns a one-cycle `mem_ready` pulse with read data. The requester holds its request until it sees `mem_ready`.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; must be a power of two.
- `LATENCY`, 2: number of BUSY cycles before the access; must be at least 1.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  read request; held by the requester until `mem_ready`.
- `mem_write`  in  1  write request; held by the requester until `mem_ready`.
- `addr`  in  32  byte address of the access.
- `din`  in  32  write data.
- `dout`  out  32  read data, registered.
- `mem_ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever a request is in flight (state is not IDLE).
- `req_conflict`  out  1  sticky flag: `mem_read` and `mem_write` were both high when a request was accepted.

## Operation
- Word index = `addr[log2(DEPTH)+1:2]`.
  - `addr[1:0]` is ignored; no misalignment handling.
  - Upper address bits are ignored, so the index wraps modulo DEPTH.
- States are IDLE, BUSY and DONE.
- IDLE:
  - If `mem_write` or `mem_read` is high, latch `addr`, `din` and the op, and load the counter with LATENCY-1. Next state is BUSY.
  - If both requests are high, the op is write and `req_conflict` is set.
  - With no request, stay in IDLE.
- BUSY:
  - If the counter is nonzero, decrement it and stay in BUSY.
  - If the counter is 0, perform the access at this edge and go to DONE.
    - Write: array[idx] <= latched din.
    - Read: `dout` <= array[idx].
- DONE: `mem_ready`=1 for exactly this cycle. Next state is IDLE unconditionally. Requests seen in DONE are ignored.
- Request inputs are sampled only in IDLE.
  - Deasserting or changing `mem_read`, `mem_write`, `addr` or `din` during BUSY does not affect the in-flight access; a latched write still commits.
- `dout` changes only when a read completes. After a write completes it keeps the last read value.
- Array contents are not cleared by reset.
- `req_conflict` is cleared only by reset.

## Timing
- Reset values: state=IDLE, `dout`=0, `mem_ready`=0, `busy`=0, `req_conflict`=0, counter=0.
- Request first seen in IDLE in cycle T:
  - `busy` is high in cycles T+1 .. T+LATENCY+1.
  - The access occurs at the edge ending cycle T+LATENCY.
  - `mem_ready`=1 and `dout` is valid in cycle T+LATENCY+1.
  - State is IDLE in cycle T+LATENCY+2.
- Request-to-ready latency is LATENCY+1 cycles. Minimum spacing between accepted requests is LATENCY+2 cycles.
- Back-to-back: a request held or reasserted in cycle T+LATENCY+2 is accepted there.
- Read-after-write to the same word returns the new data, because the write commits before the next request can be accepted.
- Reset mid-operation, in BUSY or DONE:
  - Next cycle is IDLE with `mem_ready`=0.
  - A pending write that has not yet reached its access edge is discarded; the array is unchanged.
  - Reset coinciding with the access edge also suppresses the access: reset has priority.
- `mem_ready` is never high in two consecutive cycles.

## Test plan
- Basic write then read, LATENCY=2.
  - Stimulus: write `addr`=0x10, `din`=0xDEADBEEF in cycle 0, held; then read 0x10.
  - Required: write `mem_ready` in cycle 3; read `mem_ready` in cycle 7 with `dout`=0xDEADBEEF.
  - Required: `dout` unchanged (0) during and after the write.
- Input changes mid-flight.
  - Stimulus: start a write to 0x20 with 0x11111111; in cycle 1 change `din` to 0x22222222 and drop `mem_write`.
  - Required: a later read of 0x20 returns 0x11111111; `mem_ready` still pulses in cycle 3.
- Wrap and ignored bits, DEPTH=1024.
  - Stimulus: write 0xA5A5A5A5 to `addr`=0x1003.
  - Required: a read of `addr`=0x0000 returns 0xA5A5A5A5 (index 0 after wrap, low two bits ignored).
- Conflict.
  - Stimulus: `mem_read`=`mem_write`=1, `addr`=0x8, `din`=0x5.
  - Required: treated as a write; `req_conflict`=1 from cycle 1 until reset; a read of 0x8 returns 0x5.
- Reset mid-operation.
  - Stimulus: write 0xCAFE to 0x30 (previously 0); assert `reset` in cycle 2.
  - Required: cycle 3 is IDLE, `busy`=0, no `mem_ready`; a subsequent read of 0x30 returns 0.
- LATENCY=1, back-to-back requests.
  - Stimulus: two reads held continuously.
  - Required: `mem_ready` in cycles 2 and 5, never in consecutive cycles; `busy` low only in cycles 0 and 3.
